synaptic_conductance_update: RTL and testbench
==============================================

// Module: synaptic_conductance_update
// PURPOSE
//  Producer of the per-neuron synaptic conductance g consumed by the IPSC datapath.
//  Per time step it computes g_new = g_old - g_old*DeltaT/Tausyn + WeightSum.
//  WeightSum is the spike-weighted sum for the step.
//  One neuron per transaction, valid/ready in and out; multi-cycle sequential divider.
//  Sits between the conductance RAM read port and the IPSC/membrane update stage.
// PARAMETERS
//  INTEGER_WIDTH    32  integer bits of fixed-point data
//  DATA_WIDTH_FRAC  32  fractional bits of fixed-point data
//  DATA_WIDTH       INTEGER_WIDTH+DATA_WIDTH_FRAC  total signed Q(I.F) width
//  DELTAT_WIDTH     4   DeltaT width; unsigned fraction, value = DeltaT/2^DELTAT_WIDTH
//  NEURON_ID_WIDTH  11  neuron tag width
// PORTS
//  Clock        in   1              rising-edge clock
//  Reset        in   1              asynchronous, active-low
//  InValid      in   1              input transaction valid
//  InReady      out  1              block can accept input
//  NeuronIDIn   in   NEURON_ID_WIDTH  tag, passed through unchanged
//  gIn          in   DATA_WIDTH     g_old, signed Q(I.F)
//  WeightSumIn  in   DATA_WIDTH     step weight sum, signed Q(I.F)
//  DeltaT       in   DELTAT_WIDTH   time step, unsigned fraction
//  Tausyn       in   INTEGER_WIDTH  synaptic time constant, unsigned integer
//  OutValid     out  1              result valid
//  OutReady     in   1              downstream accepts result
//  NeuronIDOut  out  NEURON_ID_WIDTH  tag of result
//  gOut         out  DATA_WIDTH     g_new, signed Q(I.F)
//  DivByZero    out  1              Tausyn was 0 for this result
// BEHAVIOUR
//  - Reset low: state IDLE; InReady=1, OutValid=0, gOut=0, NeuronIDOut=0, DivByZero=0.
//    Reset is asynchronous and aborts any in-flight transaction; the result is discarded.
//  - Input operands are registered on the accept edge (InValid&InReady). Inputs are don't-care afterwards.
//  - InReady=1 only in IDLE. Transactions do not overlap.
//  - States and transitions:
//    IDLE -(accept)-> MULT
//    MULT -> DIV (iteration counter=0)
//    DIV runs DATA_WIDTH iterations, then -> ADD
//    ADD -> DONE
//    DONE -(OutReady)-> IDLE
//  - Latency: OutValid rises DATA_WIDTH+2 edges after the accept edge (66 at defaults).
//  - In DONE, OutValid, gOut, NeuronIDOut and DivByZero are stable until OutReady=1.
//    OutReady while not valid is ignored.
//  - MULT: P = |gIn| * {DeltaT, zeros} as a fraction. Keep the Q(I.F) product bits; truncate low bits.
//  - DIV: unsigned restoring division Dq = P / Tausyn, one quotient bit per cycle.
//    The quotient is already Q(I.F), with no shift. It truncates toward zero; the sign of gIn is restored after.
//  - Tausyn==0: the decay term is forced to 0 and DivByZero=1 with this result. The state sequence and latency are unchanged.
//  - DeltaT==0: decay term is 0 and the result is gIn+WeightSumIn.
//  - ADD: S = gIn - Dq + WeightSumIn, computed at DATA_WIDTH+2 bits.
//    S is saturated to [0, 2^(DATA_WIDTH-1)-1] because conductance is non-negative.
// STRUCTURE
//  - Shared package cynapse_fixed_pkg:
//    width localparams
//    DATA_MAX/DATA_MIN constants
//    saturate_signed function
//    FSM state enum (IDLE, MULT, DIV, ADD, DONE)
//  - One sub-module, fixed_seq_divider.
//    Unsigned restoring divider with start/busy/done.
//    Width is a parameter. Dividing by 0 returns 0 and sets a div0 flag.
//  - The top level holds the FSM, operand registers, the multiplier and the saturating adder.
// TESTING (defaults: Q32.32)
//  1. Decay case.
//     Stimulus: gIn=0x2_00000000, DeltaT=8, Tausyn=5, WeightSumIn=0, tag 7.
//     Expected: gOut=0x1_CCCCCCCD, NeuronIDOut=7, OutValid exactly 66 edges after accept.
//  2. Decay plus weight.
//     Stimulus: same as 1 with WeightSumIn=0x0_80000000.
//     Expected: gOut=0x2_4CCCCCCD, DivByZero=0.
//  3. Saturation and negative clamp.
//     Stimulus A: gIn=0x7FFFFFFF_FFFFFFFF, DeltaT=0, WeightSumIn=0x1_00000000. Expected: gOut=0x7FFFFFFF_FFFFFFFF.
//     Stimulus B: gIn=0, WeightSumIn=-0x1_00000000. Expected: gOut=0.
//  4. Divide by zero.
//     Stimulus: Tausyn=0, gIn=0x3_00000000, DeltaT=15, WeightSumIn=0x0_40000000.
//     Expected: gOut=0x3_40000000, DivByZero=1, latency 66.
//  5. Backpressure.
//     Stimulus: hold OutReady=0 for 10 cycles after OutValid.
//     Expected: outputs stable; InReady=0 throughout. With OutReady=1, IDLE on the next edge and InReady=1.
//  6. Reset mid-DIV.
//     Stimulus: drop Reset at iteration 20.
//     Expected: asynchronous clear to the reset values. After release, a fresh test-1 transaction returns the test-1 values.

Source files
------------

// File: rtl/cynapse_fixed_pkg.sv
// Shared fixed-point definitions for the Cynapse conductance datapath:
// default widths, signed range limits, saturation helper and FSM states.
package cynapse_fixed_pkg;

    localparam int unsigned FX_INTEGER_WIDTH   = 32;
    localparam int unsigned FX_FRAC_WIDTH      = 32;
    localparam int unsigned FX_DATA_WIDTH      = FX_INTEGER_WIDTH + FX_FRAC_WIDTH;
    localparam int unsigned FX_DELTAT_WIDTH    = 4;
    localparam int unsigned FX_NEURON_ID_WIDTH = 11;

    localparam logic [FX_DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(FX_DATA_WIDTH-1){1'b1}}};
    localparam logic [FX_DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(FX_DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        ADD,
        DONE
    } state_t;

    // Clamp a value carrying two guard bits into the signed data range.
    function automatic logic [FX_DATA_WIDTH-1:0] saturate_signed(
        input logic signed [FX_DATA_WIDTH+1:0] x
    );
        logic signed [FX_DATA_WIDTH+1:0] hi;
        logic signed [FX_DATA_WIDTH+1:0] lo;
        hi = signed'({2'b00, DATA_MAX});
        lo = signed'({2'b11, DATA_MIN});
        if (x > hi) begin
            return DATA_MAX;
        end else if (x < lo) begin
            return DATA_MIN;
        end else begin
            return x[FX_DATA_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/fixed_seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// done is high during the final iteration cycle; quotient is final after that edge.
// A zero divisor yields a zero quotient and raises div0.
module fixed_seq_divider #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic             div0
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, dsr};
    assign done     = busy && (count == LAST);
    assign quotient = div0 ? '0 : quo;

    // Load operands on start, then shift-subtract one bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            quo   <= '0;
            dsr   <= '0;
            count <= '0;
            busy  <= 1'b0;
            div0  <= 1'b0;
        end else if (start) begin
            rem   <= '0;
            quo   <= dividend;
            dsr   <= divisor;
            count <= '0;
            busy  <= 1'b1;
            div0  <= (divisor == '0);
        end else if (busy) begin
            if (shifted >= {1'b0, dsr}) begin
                rem <= diff[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= shifted[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
            count <= count + 1'b1;
            if (count == LAST) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/synaptic_conductance_update.sv
// Per-neuron conductance update: g_new = g - g*DeltaT/Tausyn + WeightSum,
// clamped to the non-negative signed range. One transaction at a time.
module synaptic_conductance_update
    import cynapse_fixed_pkg::*;
#(
    parameter int unsigned INTEGER_WIDTH   = FX_INTEGER_WIDTH,
    parameter int unsigned DATA_WIDTH_FRAC = FX_FRAC_WIDTH,
    parameter int unsigned DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int unsigned DELTAT_WIDTH    = FX_DELTAT_WIDTH,
    parameter int unsigned NEURON_ID_WIDTH = FX_NEURON_ID_WIDTH
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [NEURON_ID_WIDTH-1:0] NeuronIDIn,
    input  logic [DATA_WIDTH-1:0]      gIn,
    input  logic [DATA_WIDTH-1:0]      WeightSumIn,
    input  logic [DELTAT_WIDTH-1:0]    DeltaT,
    input  logic [INTEGER_WIDTH-1:0]   Tausyn,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [NEURON_ID_WIDTH-1:0] NeuronIDOut,
    output logic [DATA_WIDTH-1:0]      gOut,
    output logic                       DivByZero
);

    localparam int unsigned DW  = DATA_WIDTH;
    localparam int unsigned DTW = DELTAT_WIDTH;

    state_t state, state_nx;

    logic [DW-1:0]              gin_r;
    logic [DW-1:0]              ws_r;
    logic [DTW-1:0]             dt_r;
    logic [INTEGER_WIDTH-1:0]   tau_r;
    logic [NEURON_ID_WIDTH-1:0] id_r;

    logic                       accept;
    logic                       div_start;
    logic                       div_busy;
    logic                       div_done;
    logic                       div0;
    logic [DW-1:0]              quo;
    logic [DW-1:0]              divisor;

    logic [DW-1:0]              gmag;
    logic [DW+DTW-1:0]          prod;
    logic [DW-1:0]              pfrac;
    logic signed [DW+1:0]       decay_s;
    logic signed [DW+1:0]       sum_s;
    logic [DW-1:0]              gnew;

    assign accept = InValid && InReady;

    // Magnitude times DeltaT fraction; dropping the low DTW bits keeps Q(I.F).
    assign gmag    = gin_r[DW-1] ? ('0 - gin_r) : gin_r;
    assign prod    = {{DTW{1'b0}}, gmag} * {{DW{1'b0}}, dt_r};
    assign pfrac   = prod[DW+DTW-1:DTW];
    assign divisor = {{(DW-INTEGER_WIDTH){1'b0}}, tau_r};

    // Decay carries the sign of g; guard bits keep the sum exact before clamping.
    assign decay_s = gin_r[DW-1] ? -signed'({2'b00, quo}) : signed'({2'b00, quo});
    assign sum_s   = signed'({{2{gin_r[DW-1]}}, gin_r}) - decay_s
                   + signed'({{2{ws_r[DW-1]}}, ws_r});
    assign gnew    = sum_s[DW+1] ? '0 : saturate_signed(sum_s);

    fixed_seq_divider #(
        .WIDTH(DW)
    ) u_div (
        .clk      (Clock),
        .rst_n    (Reset),
        .start    (div_start),
        .dividend (pfrac),
        .divisor  (divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quo),
        .div0     (div0)
    );

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nx  = state;
        InReady   = 1'b0;
        OutValid  = 1'b0;
        div_start = 1'b0;
        case (state)
            IDLE: begin
                InReady = !div_busy;
                if (InValid && !div_busy) begin
                    state_nx = MULT;
                end
            end
            MULT: begin
                div_start = 1'b1;
                state_nx  = DIV;
            end
            DIV: begin
                if (div_done) begin
                    state_nx = ADD;
                end
            end
            ADD: begin
                state_nx = DONE;
            end
            DONE: begin
                OutValid = 1'b1;
                if (OutReady) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Capture operands on accept.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            gin_r <= '0;
            ws_r  <= '0;
            dt_r  <= '0;
            tau_r <= '0;
            id_r  <= '0;
        end else if (accept) begin
            gin_r <= gIn;
            ws_r  <= WeightSumIn;
            dt_r  <= DeltaT;
            tau_r <= Tausyn;
            id_r  <= NeuronIDIn;
        end
    end

    // Register the result leaving ADD; it holds through DONE until taken.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            gOut        <= '0;
            NeuronIDOut <= '0;
            DivByZero   <= 1'b0;
        end else if (state == ADD) begin
            gOut        <= gnew;
            NeuronIDOut <= id_r;
            DivByZero   <= div0;
        end
    end

endmodule

// File: tb/tb_synaptic_conductance_update.sv
// Directed bench for synaptic_conductance_update at Q32.32 defaults.
module tb_synaptic_conductance_update;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [10:0] NeuronIDIn = '0;
    logic [63:0] gIn = '0;
    logic [63:0] WeightSumIn = '0;
    logic [3:0]  DeltaT = '0;
    logic [31:0] Tausyn = '0;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic [10:0] NeuronIDOut;
    logic [63:0] gOut;
    logic        DivByZero;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [63:0] held_g;

    synaptic_conductance_update dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .InValid     (InValid),
        .InReady     (InReady),
        .NeuronIDIn  (NeuronIDIn),
        .gIn         (gIn),
        .WeightSumIn (WeightSumIn),
        .DeltaT      (DeltaT),
        .Tausyn      (Tausyn),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .NeuronIDOut (NeuronIDOut),
        .gOut        (gOut),
        .DivByZero   (DivByZero)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Drive one transaction, scramble inputs after accept, wait for OutValid.
    task automatic send(input logic [63:0] g, input logic [63:0] ws, input logic [3:0] dt,
                        input logic [31:0] tau, input logic [10:0] id, output int latency);
        @(negedge Clock);
        InValid     = 1'b1;
        gIn         = g;
        WeightSumIn = ws;
        DeltaT      = dt;
        Tausyn      = tau;
        NeuronIDIn  = id;
        @(posedge Clock);
        @(negedge Clock);
        InValid     = 1'b0;
        gIn         = {$urandom, $urandom};
        WeightSumIn = {$urandom, $urandom};
        DeltaT      = 4'($urandom);
        Tausyn      = $urandom;
        NeuronIDIn  = 11'($urandom);
        latency = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge Clock);
            latency++;
            @(negedge Clock);
            if (OutValid) break;
        end
    endtask

    // With OutReady high, let the DONE->IDLE edge pass.
    task automatic drain();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    initial begin
        repeat (3) @(negedge Clock);
        check("rst_inready", 64'(InReady), 64'd1);
        check("rst_outvalid", 64'(OutValid), 64'd0);
        check("rst_gout", gOut, 64'd0);
        check("rst_id", 64'(NeuronIDOut), 64'd0);
        check("rst_dbz", 64'(DivByZero), 64'd0);
        Reset = 1'b1;

        // 1: pure decay, 2.0 - 2.0*0.5/5
        send(64'h0000_0002_0000_0000, 64'h0, 4'd8, 32'd5, 11'd7, lat);
        check("t1_lat", 64'(lat), 64'd66);
        check("t1_gout", gOut, 64'h0000_0001_CCCC_CCCD);
        check("t1_id", 64'(NeuronIDOut), 64'd7);
        check("t1_dbz", 64'(DivByZero), 64'd0);
        drain();
        check("t1_idle", 64'(InReady), 64'd1);

        // 2: decay plus 0.5 weight
        send(64'h0000_0002_0000_0000, 64'h0000_0000_8000_0000, 4'd8, 32'd5, 11'd12, lat);
        check("t2_gout", gOut, 64'h0000_0002_4CCC_CCCD);
        check("t2_dbz", 64'(DivByZero), 64'd0);
        check("t2_id", 64'(NeuronIDOut), 64'd12);
        drain();

        // 3A: positive overflow saturates
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000, 4'd0, 32'd5, 11'd1, lat);
        check("t3a_gout", gOut, 64'h7FFF_FFFF_FFFF_FFFF);
        drain();

        // 3B: negative result clamps to zero
        send(64'h0, 64'hFFFF_FFFF_0000_0000, 4'd8, 32'd5, 11'd2, lat);
        check("t3b_gout", gOut, 64'h0);
        drain();

        // Negative g: -2.0 - (-0.2) + 3.0 = 1.2 (truncated)
        send(64'hFFFF_FFFE_0000_0000, 64'h0000_0003_0000_0000, 4'd8, 32'd5, 11'd3, lat);
        check("neg_gout", gOut, 64'h0000_0001_3333_3333);
        drain();

        // 4: divide by zero forces decay to 0
        send(64'h0000_0003_0000_0000, 64'h0000_0000_4000_0000, 4'd15, 32'd0, 11'd4, lat);
        check("t4_lat", 64'(lat), 64'd66);
        check("t4_gout", gOut, 64'h0000_0003_4000_0000);
        check("t4_dbz", 64'(DivByZero), 64'd1);
        drain();

        // 5: backpressure holds outputs
        OutReady = 1'b0;
        send(64'h0000_0002_0000_0000, 64'h0000_0000_8000_0000, 4'd8, 32'd5, 11'd9, lat);
        held_g = gOut;
        check("t5_gout", held_g, 64'h0000_0002_4CCC_CCCD);
        for (int c = 0; c < 10; c++) begin
            @(negedge Clock);
            check("t5_hold_valid", 64'(OutValid), 64'd1);
            check("t5_hold_g", gOut, held_g);
            check("t5_hold_inready", 64'(InReady), 64'd0);
        end
        check("t5_hold_id", 64'(NeuronIDOut), 64'd9);
        OutReady = 1'b1;
        drain();
        check("t5_release_valid", 64'(OutValid), 64'd0);
        check("t5_release_inready", 64'(InReady), 64'd1);

        // 6: asynchronous reset in the middle of the divide
        @(negedge Clock);
        InValid     = 1'b1;
        gIn         = 64'h0000_0002_0000_0000;
        WeightSumIn = 64'h0;
        DeltaT      = 4'd8;
        Tausyn      = 32'd5;
        NeuronIDIn  = 11'd7;
        @(posedge Clock);
        @(negedge Clock);
        InValid = 1'b0;
        repeat (21) @(posedge Clock);
        #2 Reset = 1'b0;
        #1;
        check("t6_rst_gout", gOut, 64'h0);
        check("t6_rst_valid", 64'(OutValid), 64'd0);
        check("t6_rst_inready", 64'(InReady), 64'd1);
        check("t6_rst_id", 64'(NeuronIDOut), 64'd0);
        check("t6_rst_dbz", 64'(DivByZero), 64'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        send(64'h0000_0002_0000_0000, 64'h0, 4'd8, 32'd5, 11'd7, lat);
        check("t6_lat", 64'(lat), 64'd66);
        check("t6_gout", gOut, 64'h0000_0001_CCCC_CCCD);
        check("t6_id", 64'(NeuronIDOut), 64'd7);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
